// File: rtl/nes_dma_pkg.sv
// Shared definitions for the sprite DMA engine: state encoding and the
// default trigger / OAM data port addresses.
package nes_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_DMC   = 3'd4
  } dma_state_t;

  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DST_ADDR_DEF  = 16'h2004;

endpackage

// File: rtl/spr_dma_engine.sv
// Sprite DMA engine: copies one source page to the OAM data port as
// alternating read/write beats, with an interleaved DMC sample-fetch channel.
module spr_dma_engine
  import nes_dma_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 8,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = TRIG_ADDR_DEF,
  parameter logic [ADDR_W-1:0] DST_ADDR  = DST_ADDR_DEF,
  parameter bit                ALIGN_EN  = 1'b1,
  parameter bit                DMC_EN    = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic              i_bus_wn,
  input  logic [DATA_W-1:0] i_bus_wdata,
  input  logic              i_cpu_odd,
  output logic              o_cpu_halt,
  output logic              o_spr_req,
  input  logic              i_spr_gnt,
  output logic [ADDR_W-1:0] o_spr_addr,
  output logic              o_spr_wn,
  output logic [DATA_W-1:0] o_spr_wdata,
  input  logic [DATA_W-1:0] i_spr_rdata,
  input  logic              i_dmc_req,
  input  logic [ADDR_W-1:0] i_dmc_addr,
  output logic              o_dmc_ack,
  output logic [DATA_W-1:0] o_dmc_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int PAGE_W = ADDR_W - CNT_W;
  localparam int EXT_W  = (PAGE_W > DATA_W) ? PAGE_W : DATA_W;

  dma_state_t        state;
  logic [PAGE_W-1:0] page;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] buffer;
  logic [DATA_W-1:0] dmc_data;
  logic              pending;
  logic              dmc_ack;
  logic              done;

  logic [EXT_W-1:0]  wdata_ext;
  logic              trigger;
  logic              dmc_req;

  // Zero-extend so narrow counters (wide pages) still take the page from the write data.
  assign wdata_ext = EXT_W'(i_bus_wdata);
  assign trigger   = (i_bus_addr == TRIG_ADDR) && !i_bus_wn;
  assign dmc_req   = DMC_EN && i_dmc_req;

  // pending marks an accepted OAM transfer that still has beats left, so a
  // DMC fetch knows whether to resume the copy or drop back to idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      page     <= '0;
      cnt      <= '0;
      buffer   <= '0;
      dmc_data <= '0;
      pending  <= 1'b0;
      dmc_ack  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      dmc_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            page    <= wdata_ext[PAGE_W-1:0];
            cnt     <= '0;
            pending <= 1'b1;
          end
          if (dmc_req) begin
            state <= ST_DMC;
          end else if (trigger) begin
            state <= (ALIGN_EN && i_cpu_odd) ? ST_ALIGN : ST_RD;
          end
        end
        ST_ALIGN: begin
          state <= ST_RD;
        end
        ST_RD: begin
          if (i_spr_gnt) begin
            buffer <= i_spr_rdata;
            cnt    <= cnt + CNT_W'(1);
            state  <= ST_WR;
          end
        end
        ST_WR: begin
          if (i_spr_gnt) begin
            if (cnt == '0) begin
              state   <= ST_IDLE;
              pending <= 1'b0;
              done    <= 1'b1;
            end else if (dmc_req) begin
              state <= ST_DMC;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_DMC: begin
          if (i_spr_gnt) begin
            dmc_data <= i_spr_rdata;
            dmc_ack  <= 1'b1;
            state    <= pending ? ST_RD : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus master outputs decode straight from the registered state, so they
  // hold steady for as long as the grant is withheld.
  always_comb begin
    o_spr_req   = 1'b0;
    o_spr_wn    = 1'b1;
    o_spr_addr  = '0;
    o_spr_wdata = '0;
    case (state)
      ST_RD: begin
        o_spr_req  = 1'b1;
        o_spr_addr = {page, cnt};
      end
      ST_WR: begin
        o_spr_req   = 1'b1;
        o_spr_wn    = 1'b0;
        o_spr_addr  = DST_ADDR;
        o_spr_wdata = buffer;
      end
      ST_DMC: begin
        o_spr_req  = 1'b1;
        o_spr_addr = i_dmc_addr;
      end
      default: begin
      end
    endcase
  end

  assign o_busy     = (state != ST_IDLE);
  assign o_cpu_halt = o_busy;
  assign o_done     = done;
  assign o_dmc_ack  = dmc_ack;
  assign o_dmc_data = dmc_data;

endmodule

// File: tb/tb_spr_dma_engine.sv
// Self-checking bench for spr_dma_engine: a transaction-queue model of the
// expected bus traffic plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_spr_dma_engine;

  typedef struct packed {
    logic [15:0] addr;
    logic        wn;
    logic [7:0]  wdata;
    logic        last;
    logic        dmc;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        cpu_odd;
  logic        cpu_halt;
  logic        spr_req;
  logic        spr_gnt = 1'b1;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        dmc_ack;
  logic [7:0]  dmc_data;
  logic        busy;
  logic        done;

  logic [15:0] s_bus_addr;
  logic        s_bus_wn;
  logic [7:0]  s_bus_wdata;
  logic        s_cpu_halt;
  logic        s_spr_req;
  logic [15:0] s_spr_addr;
  logic        s_spr_wn;
  logic [7:0]  s_spr_wdata;
  logic [7:0]  s_spr_rdata;
  logic        s_dmc_req;
  logic        s_dmc_ack;
  logic [7:0]  s_dmc_data;
  logic        s_busy;
  logic        s_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   writes_seen = 0;
  logic gnt_random = 1'b0;
  logic exp_done = 1'b0;
  logic exp_ack  = 1'b0;
  logic [7:0] exp_dmc_data = 8'h00;
  txn_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave memory: every address holds a byte derived from the address itself.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign spr_rdata   = mem_byte(spr_addr);
  assign s_spr_rdata = mem_byte(s_spr_addr);

  always @(posedge clk) begin
    #1;
    spr_gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  spr_dma_engine dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bus_addr  (bus_addr),
    .i_bus_wn    (bus_wn),
    .i_bus_wdata (bus_wdata),
    .i_cpu_odd   (cpu_odd),
    .o_cpu_halt  (cpu_halt),
    .o_spr_req   (spr_req),
    .i_spr_gnt   (spr_gnt),
    .o_spr_addr  (spr_addr),
    .o_spr_wn    (spr_wn),
    .o_spr_wdata (spr_wdata),
    .i_spr_rdata (spr_rdata),
    .i_dmc_req   (dmc_req),
    .i_dmc_addr  (dmc_addr),
    .o_dmc_ack   (dmc_ack),
    .o_dmc_data  (dmc_data),
    .o_busy      (busy),
    .o_done      (done)
  );

  spr_dma_engine #(.CNT_W(4), .DMC_EN(1'b0)) dut_small (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bus_addr  (s_bus_addr),
    .i_bus_wn    (s_bus_wn),
    .i_bus_wdata (s_bus_wdata),
    .i_cpu_odd   (1'b0),
    .o_cpu_halt  (s_cpu_halt),
    .o_spr_req   (s_spr_req),
    .i_spr_gnt   (1'b1),
    .o_spr_addr  (s_spr_addr),
    .o_spr_wn    (s_spr_wn),
    .o_spr_wdata (s_spr_wdata),
    .i_spr_rdata (s_spr_rdata),
    .i_dmc_req   (s_dmc_req),
    .i_dmc_addr  (16'hC000),
    .o_dmc_ack   (s_dmc_ack),
    .o_dmc_data  (s_dmc_data),
    .o_busy      (s_busy),
    .o_done      (s_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One CPU write cycle on the slave port; returns just after the sampling edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] wdata);
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wn    = 1'b0;
    @(posedge clk);
    #1;
    bus_wn    = 1'b1;
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
  endtask

  task automatic pushTransfer(input logic [7:0] page, input int dmc_after, input logic [15:0] daddr);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] ra;
      ra = {page, 8'(i)};
      q.push_back('{addr: ra, wn: 1'b1, wdata: 8'h00, last: 1'b0, dmc: 1'b0});
      q.push_back('{addr: 16'h2004, wn: 1'b0, wdata: mem_byte(ra), last: (i == 255), dmc: 1'b0});
      if (i == dmc_after)
        q.push_back('{addr: daddr, wn: 1'b1, wdata: 8'h00, last: 1'b0, dmc: 1'b1});
    end
  endtask

  task automatic pushDmc(input logic [15:0] daddr);
    q.push_back('{addr: daddr, wn: 1'b1, wdata: 8'h00, last: 1'b0, dmc: 1'b1});
  endtask

  task automatic waitDone(input int t0, input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    checkOutput("done_seen", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (dmc_ack) break;
    end
    checkOutput("dmc_ack_seen", dmc_ack, 1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"},   spr_req,   1'b0);
    checkOutput({tag, "_wn"},    spr_wn,    1'b1);
    checkOutput({tag, "_addr"},  spr_addr,  16'h0000);
    checkOutput({tag, "_wdata"}, spr_wdata, 8'h00);
    checkOutput({tag, "_halt"},  cpu_halt,  1'b0);
    checkOutput({tag, "_busy"},  busy,      1'b0);
    checkOutput({tag, "_done"},  done,      1'b0);
    checkOutput({tag, "_ack"},   dmc_ack,   1'b0);
    checkOutput({tag, "_dmcd"},  dmc_data,  8'h00);
  endtask

  // Every cycle: bus traffic must match the head of the expected transaction
  // queue, and done/ack must follow exactly one cycle after the granting beat.
  always @(negedge clk) begin
    txn_t h;
    if (rst) begin
      q.delete();
      exp_done = 1'b0;
      exp_ack  = 1'b0;
    end else begin
      checkOutput("halt_eq_busy", cpu_halt, busy);
      checkOutput("busy", busy, q.size() != 0);
      checkOutput("done", done, exp_done);
      checkOutput("dmc_ack", dmc_ack, exp_ack);
      if (exp_ack) checkOutput("dmc_data", dmc_data, exp_dmc_data);
      checkOutput("s_dmc_ack", s_dmc_ack, 1'b0);
      checkOutput("s_dmc_data", s_dmc_data, 8'h00);
      exp_done = 1'b0;
      exp_ack  = 1'b0;
      if (spr_req) begin
        if (q.size() == 0) begin
          checkOutput("req_without_txn", spr_req, 1'b0);
        end else begin
          h = q[0];
          checkOutput("bus_addr", spr_addr, h.addr);
          checkOutput("bus_wn", spr_wn, h.wn);
          if (!h.wn) checkOutput("bus_wdata", spr_wdata, h.wdata);
          if (spr_gnt) begin
            h = q.pop_front();
            if (!h.wn) writes_seen++;
            exp_done = h.last;
            if (h.dmc) begin
              exp_ack      = 1'b1;
              exp_dmc_data = mem_byte(h.addr);
            end
          end
        end
      end else begin
        checkOutput("idle_addr", spr_addr, 16'h0000);
        checkOutput("idle_wn", spr_wn, 1'b1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int lat;
    int base;
    logic saw_done;
    logic [15:0] sa;

    rst = 1'b1; bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    cpu_odd = 1'b0; dmc_req = 1'b0; dmc_addr = 16'h0000;
    s_bus_addr = 16'h0000; s_bus_wn = 1'b1; s_bus_wdata = 8'h00; s_dmc_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] plain transfer, even cycle");
    applyStimulus(16'h4014, 8'h02);
    t0 = cyc;
    pushTransfer(8'h02, -1, 16'h0000);
    checkOutput("first_rd_addr", spr_addr, 16'h0200);
    waitDone(t0, 2000, lat);
    checkOutput("latency_even", lat, 512);
    checkOutput("drained_even", q.size(), 0);

    $display("[TB] aligned transfer, odd cycle");
    cpu_odd = 1'b1;
    applyStimulus(16'h4014, 8'h03);
    cpu_odd = 1'b0;
    t0 = cyc;
    pushTransfer(8'h03, -1, 16'h0000);
    checkOutput("align_no_req", spr_req, 1'b0);
    checkOutput("align_busy", busy, 1'b1);
    waitDone(t0, 2000, lat);
    checkOutput("latency_odd", lat, 513);

    $display("[TB] DMC fetch after beat 5");
    dmc_addr = 16'hC000;
    applyStimulus(16'h4014, 8'h02);
    t0 = cyc;
    pushTransfer(8'h02, 5, 16'hC000);
    repeat (11) @(posedge clk);
    #1;
    dmc_req = 1'b1;
    waitAck(10);
    checkOutput("dmc_data_c000", dmc_data, 8'h65);
    checkOutput("resume_addr", spr_addr, 16'h0206);
    dmc_req = 1'b0;
    waitDone(t0, 2000, lat);
    checkOutput("latency_dmc", lat, 513);

    $display("[TB] trigger and DMC request together");
    dmc_addr = 16'h8001;
    dmc_req  = 1'b1;
    applyStimulus(16'h4014, 8'h04);
    t0 = cyc;
    pushDmc(16'h8001);
    pushTransfer(8'h04, -1, 16'h0000);
    waitAck(10);
    checkOutput("dmc_data_8001", dmc_data, 8'h24);
    checkOutput("pending_start", spr_addr, 16'h0400);
    dmc_req = 1'b0;
    waitDone(t0, 2000, lat);
    checkOutput("latency_pending", lat, 513);

    $display("[TB] DMC fetch from idle");
    dmc_addr = 16'hC000;
    dmc_req  = 1'b1;
    @(posedge clk);
    #1;
    pushDmc(16'hC000);
    waitAck(10);
    dmc_req = 1'b0;
    checkOutput("dmc_idle_data", dmc_data, 8'h65);
    @(posedge clk);
    #1;
    checkOutput("dmc_idle_back", busy, 1'b0);

    $display("[TB] random grant");
    base = writes_seen;
    gnt_random = 1'b1;
    applyStimulus(16'h4014, 8'h05);
    t0 = cyc;
    pushTransfer(8'h05, -1, 16'h0000);
    waitDone(t0, 4000, lat);
    gnt_random = 1'b0;
    checkOutput("random_writes", writes_seen - base, 256);
    checkOutput("random_drained", q.size(), 0);

    $display("[TB] retrigger ignored, reset at beat 100");
    applyStimulus(16'h4014, 8'h03);
    t0 = cyc;
    pushTransfer(8'h03, -1, 16'h0000);
    repeat (50) @(posedge clk);
    #1;
    applyStimulus(16'h4014, 8'h07);
    repeat (149) @(posedge clk);
    #1;
    checkOutput("beat100_addr", spr_addr, 16'h0364);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetOutputs("abort");
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("no_done_after_abort", saw_done, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] CNT_W=4 instance");
    s_bus_addr  = 16'h4014;
    s_bus_wdata = 8'h02;
    s_bus_wn    = 1'b0;
    @(posedge clk);
    #1;
    s_bus_wn    = 1'b1;
    s_bus_addr  = 16'h0000;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      sa = {12'h002, 4'(i)};
      checkOutput("s_rd_addr", s_spr_addr, sa);
      checkOutput("s_rd_wn", s_spr_wn, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("s_wr_addr", s_spr_addr, 16'h2004);
      checkOutput("s_wr_data", s_spr_wdata, mem_byte(sa));
      @(posedge clk);
      #1;
    end
    checkOutput("s_done", s_done, 1'b1);
    checkOutput("s_latency", cyc - t0, 32);
    checkOutput("s_idle", s_busy, 1'b0);
    checkOutput("s_halt", s_cpu_halt, 1'b0);
    checkOutput("s_req", s_spr_req, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
